// File: rtl/oserdes_tx_ctrl_if.sv
// Word-stream bundle between the fabric source, the sequencer and the O_SERDES data/strobe pins.
// The sequencer uses the master modport and the source/serializer side uses the slave modport.
interface oserdes_tx_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] s_data;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] d_out;
    logic             load_word;
    logic             serdes_rst;

    modport master (
        input  s_data, s_valid,
        output s_ready, d_out, load_word, serdes_rst
    );

    modport slave (
        output s_data, s_valid,
        input  s_ready, d_out, load_word, serdes_rst
    );
endinterface

// File: rtl/oserdes_tx_ctrl.sv
// Transmit sequencer for a 4:1 O_SERDES lane: it qualifies PLL lock, holds the serializer in reset,
// sends the training words, then moves source words onto D with timed LOAD_WORD strobes.
module oserdes_tx_ctrl #(
    parameter int unsigned      WIDTH       = 4,
    parameter int unsigned      WORD_PERIOD = 1,
    parameter int unsigned      LOCK_WAIT   = 16,
    parameter int unsigned      RST_CYCLES  = 4,
    parameter int unsigned      TRAIN_WORDS = 8,
    parameter logic [WIDTH-1:0] TRAIN_WORD  = WIDTH'(4'b1010),
    parameter logic [WIDTH-1:0] IDLE_WORD   = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pll_lock,
    input  logic                clr_status,
    oserdes_tx_ctrl_if.master   bus,
    output logic                link_up,
    output logic                lock_lost,
    output logic [15:0]         underrun_cnt
);
    localparam int unsigned LOCK_W = (LOCK_WAIT   > 1) ? $clog2(LOCK_WAIT)   : 1;
    localparam int unsigned RST_W  = (RST_CYCLES  > 1) ? $clog2(RST_CYCLES)  : 1;
    localparam int unsigned TRN_W  = (TRAIN_WORDS > 1) ? $clog2(TRAIN_WORDS) : 1;
    localparam int unsigned PER_W  = (WORD_PERIOD > 1) ? $clog2(WORD_PERIOD) : 1;

    typedef enum logic [1:0] {WAIT_LOCK, SER_RST, TRAIN, RUN} state_t;

    state_t             state_q, state_d;
    logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic [RST_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic [TRN_W-1:0]   trn_cnt_q, trn_cnt_d;
    logic [PER_W-1:0]   per_cnt_q, per_cnt_d;
    logic [WIDTH-1:0]   d_out_d;
    logic               load_d;
    logic               serdes_rst_d;
    logic               link_up_d;
    logic               lock_lost_d;
    logic [15:0]        underrun_d;
    logic               active_c;
    logic               tick_c;

    // A tick is swallowed on a lock-drop cycle so nothing is loaded or accepted
    assign active_c    = (state_q == TRAIN) || (state_q == RUN);
    assign tick_c      = active_c && (per_cnt_q == '0) && pll_lock;
    assign bus.s_ready = (state_q == RUN) && tick_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= WAIT_LOCK;
            lock_cnt_q     <= '0;
            rst_cnt_q      <= '0;
            trn_cnt_q      <= '0;
            per_cnt_q      <= '0;
            bus.d_out      <= IDLE_WORD;
            bus.load_word  <= 1'b0;
            bus.serdes_rst <= 1'b1;
            link_up        <= 1'b0;
            lock_lost      <= 1'b0;
            underrun_cnt   <= '0;
        end else begin
            state_q        <= state_d;
            lock_cnt_q     <= lock_cnt_d;
            rst_cnt_q      <= rst_cnt_d;
            trn_cnt_q      <= trn_cnt_d;
            per_cnt_q      <= per_cnt_d;
            bus.d_out      <= d_out_d;
            bus.load_word  <= load_d;
            bus.serdes_rst <= serdes_rst_d;
            link_up        <= link_up_d;
            lock_lost      <= lock_lost_d;
            underrun_cnt   <= underrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        lock_cnt_d  = '0;
        rst_cnt_d   = '0;
        trn_cnt_d   = trn_cnt_q;
        per_cnt_d   = '0;
        d_out_d     = bus.d_out;
        load_d      = 1'b0;
        lock_lost_d = lock_lost;
        underrun_d  = underrun_cnt;

        case (state_q)
            WAIT_LOCK: begin
                trn_cnt_d = '0;
                if (pll_lock) begin
                    if (lock_cnt_q == LOCK_W'(LOCK_WAIT - 1)) state_d = SER_RST;
                    else lock_cnt_d = lock_cnt_q + LOCK_W'(1);
                end
            end
            SER_RST: begin
                if (rst_cnt_q == RST_W'(RST_CYCLES - 1)) state_d = TRAIN;
                else rst_cnt_d = rst_cnt_q + RST_W'(1);
            end
            TRAIN: begin
                if (tick_c) begin
                    d_out_d = TRAIN_WORD;
                    load_d  = 1'b1;
                    if (trn_cnt_q == TRN_W'(TRAIN_WORDS - 1)) state_d = RUN;
                    else trn_cnt_d = trn_cnt_q + TRN_W'(1);
                end
            end
            RUN: begin
                if (tick_c) begin
                    load_d = 1'b1;
                    if (bus.s_valid) begin
                        d_out_d = bus.s_data;
                    end else begin
                        d_out_d = IDLE_WORD;
                        if (underrun_cnt != 16'hFFFF) underrun_d = underrun_cnt + 16'd1;
                    end
                end
            end
            default: state_d = WAIT_LOCK;
        endcase

        if (active_c) begin
            per_cnt_d = (per_cnt_q == PER_W'(WORD_PERIOD - 1)) ? '0 : per_cnt_q + PER_W'(1);
        end

        // Losing lock after acceptance restarts the whole bring-up
        if ((state_q != WAIT_LOCK) && !pll_lock) begin
            state_d     = WAIT_LOCK;
            lock_lost_d = 1'b1;
            per_cnt_d   = '0;
            rst_cnt_d   = '0;
            trn_cnt_d   = '0;
        end

        if (clr_status) begin
            lock_lost_d = 1'b0;
            underrun_d  = '0;
        end

        serdes_rst_d = (state_d == WAIT_LOCK) || (state_d == SER_RST);
        link_up_d    = (state_d == RUN);
    end
endmodule

// File: tb/tb_oserdes_tx_ctrl.sv
// Bench for oserdes_tx_ctrl: two instances (WORD_PERIOD 1 and 4) checked each cycle against a
// schedule-based model, plus directed bring-up, streaming, underrun, saturation and lock-loss cases.
`timescale 1ns/1ps
module tb_oserdes_tx_ctrl;
    localparam int unsigned LOCK_WAIT   = 16;
    localparam int unsigned RST_CYCLES  = 4;
    localparam int unsigned TRAIN_WORDS = 8;
    localparam logic [3:0]  TRAIN_WORD  = 4'b1010;
    localparam logic [3:0]  IDLE_WORD   = 4'b0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [2];
    logic       pll [2];
    logic       clr [2];
    logic       sv  [2];
    logic [3:0] sd  [2];

    logic [3:0]  od  [2];
    logic        ol  [2];
    logic        os  [2];
    logic        orr [2];
    logic        lu  [2];
    logic        ll  [2];
    logic [15:0] uc  [2];

    oserdes_tx_ctrl_if #(.WIDTH(4)) ifa ();
    oserdes_tx_ctrl_if #(.WIDTH(4)) ifb ();

    assign ifa.s_data  = sd[0];
    assign ifa.s_valid = sv[0];
    assign ifb.s_data  = sd[1];
    assign ifb.s_valid = sv[1];
    assign od[0]  = ifa.d_out;
    assign ol[0]  = ifa.load_word;
    assign os[0]  = ifa.serdes_rst;
    assign orr[0] = ifa.s_ready;
    assign od[1]  = ifb.d_out;
    assign ol[1]  = ifb.load_word;
    assign os[1]  = ifb.serdes_rst;
    assign orr[1] = ifb.s_ready;

    oserdes_tx_ctrl #(.WIDTH(4), .WORD_PERIOD(1)) dut_a (
        .clk(clk), .rst(rst[0]), .pll_lock(pll[0]), .clr_status(clr[0]), .bus(ifa),
        .link_up(lu[0]), .lock_lost(ll[0]), .underrun_cnt(uc[0])
    );

    oserdes_tx_ctrl #(.WIDTH(4), .WORD_PERIOD(4)) dut_b (
        .clk(clk), .rst(rst[1]), .pll_lock(pll[1]), .clr_status(clr[1]), .bus(ifb),
        .link_up(lu[1]), .lock_lost(ll[1]), .underrun_cnt(uc[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, inst, $time, act, exp);
        end
    endtask

    function automatic int wp_of(input int i);
        return (i == 0) ? 1 : 4;
    endfunction

    // Model: phase 0 lock wait, 1 serializer reset, 2 training, 3 run; age counts cycles in phase
    int         ph  [2];
    int         age [2];
    int         hi  [2];
    logic [3:0] e_d    [2];
    logic       e_load [2];
    logic       e_srst [2];
    logic       e_link [2];
    logic       e_lost [2];
    int         e_uc   [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit tk;
            int wp;
            wp = wp_of(i);
            if (rst[i]) begin
                ph[i] = 0; age[i] = 0; hi[i] = 0;
                e_d[i] = IDLE_WORD; e_load[i] = 1'b0; e_lost[i] = 1'b0; e_uc[i] = 0;
            end else begin
                tk = (ph[i] >= 2) && (age[i] % wp == 0) && pll[i];
                e_load[i] = tk;
                if (tk) begin
                    if (ph[i] == 2) e_d[i] = TRAIN_WORD;
                    else if (sv[i]) e_d[i] = sd[i];
                    else begin
                        e_d[i] = IDLE_WORD;
                        if (e_uc[i] < 65535) e_uc[i]++;
                    end
                end
                if (ph[i] != 0 && !pll[i]) begin
                    ph[i] = 0; age[i] = 0; hi[i] = 0; e_lost[i] = 1'b1;
                end else begin
                    case (ph[i])
                        0: begin
                            hi[i] = pll[i] ? hi[i] + 1 : 0;
                            if (hi[i] == LOCK_WAIT) begin ph[i] = 1; age[i] = 0; hi[i] = 0; end
                        end
                        1: begin
                            age[i]++;
                            if (age[i] == RST_CYCLES) begin ph[i] = 2; age[i] = 0; end
                        end
                        default: begin
                            if (ph[i] == 2 && tk && age[i] == (TRAIN_WORDS - 1) * wp) ph[i] = 3;
                            age[i]++;
                        end
                    endcase
                end
                if (clr[i]) begin e_lost[i] = 1'b0; e_uc[i] = 0; end
            end
            e_srst[i] = (ph[i] < 2);
            e_link[i] = (ph[i] == 3);
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("d_out",        i, 32'(od[i]), 32'(e_d[i]));
            chk("load_word",    i, 32'(ol[i]), 32'(e_load[i]));
            chk("serdes_rst",   i, 32'(os[i]), 32'(e_srst[i]));
            chk("link_up",      i, 32'(lu[i]), 32'(e_link[i]));
            chk("lock_lost",    i, 32'(ll[i]), 32'(e_lost[i]));
            chk("underrun_cnt", i, 32'(uc[i]), 32'(e_uc[i]));
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst[i]) chk("s_ready", i, 32'(orr[i]),
                             32'((ph[i] == 3) && (age[i] % wp_of(i) == 0) && pll[i]));
        end
    end

    // Source: advance to the next word after every accepted handshake
    logic fire [2];
    int   acc  [2];

    task automatic step();
        #1;
        fire[0] = sv[0] && ifa.s_ready;
        fire[1] = sv[1] && ifb.s_ready;
        @(posedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            if (fire[i]) begin
                sd[i] = sd[i] + 4'd1;
                acc[i]++;
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n, nl, nbad, ticks, nidle;
        int pos [3];
        logic [3:0] dprev;
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1; pll[i] = 1'b1; clr[i] = 1'b0; sv[i] = 1'b0; sd[i] = 4'h1; acc[i] = 0;
        end
        repeat (3) step();

        chk("reset_serdes_rst", 0, 32'(os[0]), 32'd1);
        chk("reset_d_out",      0, 32'(od[0]), 32'(IDLE_WORD));

        // Bring-up on A
        rst[0] = 1'b0; sv[0] = 1'b1;
        n = 0;
        while (os[0] === 1'b1 && n < 100) begin step(); n++; end
        chk("bringup_cycles", 0, 32'(n), 32'd20);
        n = 0; nl = 0; nbad = 0;
        while (lu[0] !== 1'b1 && n < 100) begin
            step(); n++;
            if (ol[0]) begin
                nl++;
                if (od[0] !== TRAIN_WORD) nbad++;
            end
        end
        chk("train_loads",     0, 32'(nl),   32'd8);
        chk("train_bad_words", 0, 32'(nbad), 32'd0);
        chk("link_up_delay",   0, 32'(n),    32'd8);

        // Streaming with a continuously valid source
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("stream_word", 0, 32'(od[0]), 32'(k));
            chk("stream_load", 0, 32'(ol[0]), 32'd1);
        end
        chk("stream_accepted", 0, 32'(acc[0]), 32'd10);
        chk("stream_underrun", 0, 32'(uc[0]),  32'd0);

        // Saturation of the underrun counter
        sv[0] = 1'b0;
        repeat (65540) step();
        chk("underrun_sat", 0, 32'(uc[0]), 32'hFFFF);
        step();
        chk("underrun_hold", 0, 32'(uc[0]), 32'hFFFF);
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        chk("clr_wins_underrun", 0, 32'(uc[0]), 32'd0);

        // Lock loss mid-RUN
        sv[0] = 1'b1;
        step();
        pll[0] = 1'b0;
        #1;
        chk("ready_on_lockdrop", 0, 32'(orr[0]), 32'd0);
        dprev = od[0];
        step();
        pll[0] = 1'b1;
        chk("lockdrop_serdes_rst", 0, 32'(os[0]), 32'd1);
        chk("lockdrop_link_up",    0, 32'(lu[0]), 32'd0);
        chk("lockdrop_lock_lost",  0, 32'(ll[0]), 32'd1);
        chk("lockdrop_load",       0, 32'(ol[0]), 32'd0);
        chk("lockdrop_d_hold",     0, 32'(od[0]), 32'(dprev));
        n = 0;
        while (lu[0] !== 1'b1 && n < 200) begin step(); n++; end
        chk("relock_cycles",     0, 32'(n),     32'd28);
        chk("lock_lost_sticky",  0, 32'(ll[0]), 32'd1);
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        chk("lock_lost_cleared", 0, 32'(ll[0]), 32'd0);

        // Synchronous reset mid-operation
        repeat (3) step();
        rst[0] = 1'b1;
        step();
        chk("midrst_d_out",      0, 32'(od[0]), 32'(IDLE_WORD));
        chk("midrst_load",       0, 32'(ol[0]), 32'd0);
        chk("midrst_serdes_rst", 0, 32'(os[0]), 32'd1);
        chk("midrst_link_up",    0, 32'(lu[0]), 32'd0);

        // Lock filter: 15 high, 1 low, then high
        rst[0] = 1'b0; pll[0] = 1'b1;
        repeat (15) step();
        pll[0] = 1'b0;
        step();
        pll[0] = 1'b1;
        chk("glitch_serdes_rst", 0, 32'(os[0]), 32'd1);
        n = 0;
        while (os[0] === 1'b1 && n < 100) begin step(); n++; end
        chk("glitch_relock_cycles", 0, 32'(n), 32'd20);

        // Instance B, WORD_PERIOD = 4
        rst[1] = 1'b0; sv[1] = 1'b1;
        n = 0;
        while (lu[1] !== 1'b1 && n < 200) begin step(); n++; end
        chk("b_link_up_delay", 1, 32'(n), 32'd49);
        repeat (8) step();
        sv[1] = 1'b0;
        ticks = 0; nidle = 0;
        for (int c = 0; c < 40; c++) begin
            if (ticks == 3) sv[1] = 1'b1;
            #1;
            if (ifb.s_ready && !sv[1]) ticks++;
            step();
            if (ol[1] && od[1] == IDLE_WORD) begin
                if (nidle < 3) pos[nidle] = c;
                nidle++;
            end
        end
        chk("b_idle_loads", 1, 32'(nidle), 32'd3);
        if (nidle >= 3) begin
            chk("b_idle_gap1", 1, 32'(pos[1] - pos[0]), 32'd4);
            chk("b_idle_gap2", 1, 32'(pos[2] - pos[1]), 32'd4);
        end
        chk("b_underrun_cnt", 1, 32'(uc[1]), 32'd3);
        clr[1] = 1'b1;
        step();
        clr[1] = 1'b0;
        chk("b_underrun_clr", 1, 32'(uc[1]), 32'd0);

        // Clear held across underrun ticks keeps the count at zero
        sv[1] = 1'b0; clr[1] = 1'b1;
        repeat (8) step();
        clr[1] = 1'b0; sv[1] = 1'b1;
        chk("b_clr_wins", 1, 32'(uc[1]), 32'd0);
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
